// File: rtl/g729_stage_sequencer_pkg.sv
// Shared encodings for the G.729 frame-level stage sequencer.
// Sequencer states, stage index map and the idle mux owner.
package g729_stage_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } seq_state_t;

    localparam int STG_LSP_INTERP = 0;
    localparam int STG_PERC_VAR   = 1;
    localparam int STG_WGT_SPEECH = 2;
    localparam int STG_OPEN_LOOP  = 3;
    localparam int STG_TARGET     = 4;
    localparam int STG_CODEBOOK   = 5;

    localparam int G729_NUM_STAGES = 6;
    localparam int MUX_SEL_IDLE    = G729_NUM_STAGES;

endpackage

// File: rtl/g729_seq_watchdog.sv
// Stage watchdog: saturating cycle counter plus limit compare.
// Only instantiated when G729_SEQ_WATCHDOG_EN is defined.
module g729_seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/g729_stage_sequencer.sv
// Frame sequencer: launches each G.729 encoder stage and owns the shared mux select.
// Optional stage watchdog enabled by defining G729_SEQ_WATCHDOG_EN.
module g729_stage_sequencer
    import g729_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = G729_NUM_STAGES,
    parameter int PRE_STAGES = 2,
    parameter int NUM_SUBFR  = 2,
    parameter int SEL_W      = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] stageDone,
    output logic [NUM_STAGES-1:0] stageStart,
    output logic [SEL_W-1:0]      muxSel,
    output logic                  subframe,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    if (((2 ** SEL_W) < NUM_STAGES + 1) || (TIMEOUT < 1) || (TIMEOUT > 65535))
    begin : g_bad_cfg
        $error("g729_stage_sequencer: illegal parameter set");
    end

    localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(NUM_STAGES);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_STAGES - 1);
    localparam logic [SEL_W-1:0] LOOP_IDX = SEL_W'(PRE_STAGES);
    localparam bit               LOOP_EN  = (PRE_STAGES < NUM_STAGES);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic             sub_q;
    logic             sub_d;
    logic             wd_expired;

`ifdef G729_SEQ_WATCHDOG_EN
    logic error_q;
    logic error_d;

    g729_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == S_LAUNCH),
        .count   ((state_q == S_ARM) || (state_q == S_WAIT)),
        .expired (wd_expired)
    );

    always_comb begin
        error_d = error_q;
        if ((state_q == S_IDLE) && start) begin
            error_d = 1'b0;
        end else if ((state_q == S_WAIT) && !stageDone[idx_q] && wd_expired) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign wd_expired = 1'b0;
    assign error      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sub_d      = sub_q;
        stageStart = '0;
        muxSel     = SEL_IDLE;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LAUNCH;
                    idx_d   = '0;
                    sub_d   = 1'b0;
                end
            end
            S_LAUNCH: begin
                stageStart[idx_q] = 1'b1;
                muxSel            = idx_q;
                busy              = 1'b1;
                state_d           = S_ARM;
            end
            // A level done left high by the previous run is not looked at here.
            S_ARM: begin
                muxSel  = idx_q;
                busy    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                muxSel = idx_q;
                busy   = 1'b1;
                if (stageDone[idx_q]) begin
                    state_d = S_NEXT;
                end else if (wd_expired) begin
                    state_d = S_FINISH;
                end
            end
            S_NEXT: begin
                muxSel = idx_q;
                busy   = 1'b1;
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LAUNCH;
                end else if (LOOP_EN && (int'(sub_q) < NUM_SUBFR - 1)) begin
                    idx_d   = LOOP_IDX;
                    sub_d   = 1'b1;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
        end
    end

    assign subframe = sub_q;

endmodule

// File: tb/tb_g729_stage_sequencer.sv
// Directed bench for g729_stage_sequencer.
// Watchdog checks follow G729_SEQ_WATCHDOG_EN.
module tb_g729_stage_sequencer;

  localparam int NS = 6;
`ifdef G729_SEQ_WATCHDOG_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NS-1:0] stageDone;
  logic [NS-1:0] stageStart;
  logic [2:0]    muxSel;
  logic          subframe;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  g729_stage_sequencer #(
    .NUM_STAGES (NS),
    .PRE_STAGES (2),
    .NUM_SUBFR  (2),
    .SEL_W      (3),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stageDone  (stageDone),
    .stageStart (stageStart),
    .muxSel     (muxSel),
    .subframe   (subframe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int tests = 0;
  int fails = 0;

  logic [NS-1:0] act_m;
  logic [NS-1:0] lvl_m;
  logic [NS-1:0] pulse_m;
  logic [NS-1:0] lvl_mode;
  logic [NS-1:0] dead;
  logic [NS-1:0] extra;
  int            cnt_m [NS];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (reset) begin
        act_m[i] <= 1'b0;
        cnt_m[i] <= 0;
        lvl_m[i] <= lvl_mode[i];
      end else begin
        if (stageStart[i]) begin
          act_m[i] <= 1'b1;
          cnt_m[i] <= 5;
        end else if (act_m[i]) begin
          if (cnt_m[i] == 0) act_m[i] <= 1'b0;
          else cnt_m[i] <= cnt_m[i] - 1;
        end
        if (act_m[i] && cnt_m[i] == 5) lvl_m[i] <= 1'b0;
        else if (pulse_m[i] && lvl_mode[i]) lvl_m[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    pulse_m = '0;
    for (int i = 0; i < NS; i++) begin
      pulse_m[i] = act_m[i] && (cnt_m[i] == 0) && !dead[i];
    end
  end

  assign stageDone = pulse_m | lvl_m | extra;

  int            cyc = 0;
  int            n_st = 0;
  int            n_done = 0;
  logic [NS-1:0] st_vec [64];
  logic          st_sf  [64];
  int            st_cyc [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((|stageStart) && n_st < 64) begin
      st_vec[n_st] <= stageStart;
      st_sf[n_st]  <= subframe;
      st_cyc[n_st] <= cyc;
      n_st         <= n_st + 1;
    end
    if (done === 1'b1) n_done <= n_done + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fail(input string tag);
    fails++;
    $error("FAIL %s", tag);
  endtask

  initial begin
    int n;
    int base;
    int dbase;
    int exp_idx [10];
    logic exp_sf [10];
    logic [NS-1:0] one;
    exp_idx = '{0, 1, 2, 3, 4, 5, 2, 3, 4, 5};
    exp_sf  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    one      = 6'b000001;
    reset    = 1'b1;
    start    = 1'b0;
    dead     = '0;
    extra    = '0;
    lvl_mode = 6'b000010;
    repeat (3) tick();

    tests++; if (stageStart !== 6'b0) fail("rst_start");
    tests++; if (muxSel !== 3'd6) fail("rst_mux");
    tests++; if (subframe !== 1'b0) fail("rst_subfr");
    tests++; if (busy !== 1'b0) fail("rst_busy");
    tests++; if (done !== 1'b0) fail("rst_done");
    tests++; if (error !== 1'b0) fail("rst_error");
    reset = 1'b0;
    tick();

    base  = n_st;
    dbase = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    tests++; if (n !== 80) fail("frame_len");
    tests++; if (busy !== 1'b0) fail("fin_busy");
    tests++; if (muxSel !== 3'd6) fail("fin_mux");
    tick();
    tests++; if (done !== 1'b0) fail("done_pulse");
    tests++; if (n_st - base !== 10) fail("n_launch");
    tests++; if (n_done - dbase !== 1) fail("n_done");
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (st_vec[base + k] !== (one << exp_idx[k])) fail("launch_vec");
      tests++;
      if (st_sf[base + k] !== exp_sf[k]) fail("launch_sf");
      tests++;
      if (st_cyc[base + k] - st_cyc[base] !== 8 * k) fail("launch_cyc");
    end

    base  = n_st;
    dbase = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 21;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    tests++; if (n !== 80) fail("busy_start_len");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    tests++; if (busy !== 1'b0) fail("ign_busy");
    tests++; if (n_st - base !== 10) fail("ign_launch");
    tests++; if (n_done - dbase !== 1) fail("ign_done");
    tests++; if (muxSel !== 3'd6) fail("ign_mux");

    base  = n_st;
    dead  = 6'b000100;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (muxSel !== 3'd2 && n < 100) begin tick(); n++; end
    tests++; if (n !== 16) fail("stg2_launch");
    repeat (3) tick();
    extra = 6'b010000;
    repeat (6) tick();
    tests++; if (muxSel !== 3'd2) fail("wrong_mux");
    tests++; if (busy !== 1'b1) fail("wrong_busy");
    tests++; if (n_st - base !== 3) fail("wrong_launch");
    dead  = '0;
    extra = 6'b000100;
    tick();
    extra = '0;
    tests++; if (muxSel !== 3'd2) fail("next_mux");
    tick();
    tests++; if (muxSel !== 3'd3) fail("stg3_mux");
    tests++; if (stageStart !== 6'b001000) fail("stg3_start");
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    tests++; if (done !== 1'b1) fail("wrong_fin");
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (muxSel !== 3'd3 && n < 100) begin tick(); n++; end
    tests++; if (n !== 24) fail("stg3_launch");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tests++; if (stageStart !== 6'b0) fail("mid_start");
    tests++; if (muxSel !== 3'd6) fail("mid_mux");
    tests++; if (subframe !== 1'b0) fail("mid_subfr");
    tests++; if (busy !== 1'b0) fail("mid_busy");
    tests++; if (done !== 1'b0) fail("mid_done");
    tests++; if (error !== 1'b0) fail("mid_error");
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (stageStart !== 6'b000001) fail("restart_vec");
    tests++; if (muxSel !== 3'd0) fail("restart_mux");
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    tests++; if (n !== 80) fail("restart_len");
    tick();

    dead  = 6'b000100;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (muxSel !== 3'd2 && n < 100) begin tick(); n++; end
    tests++; if (n !== 16) fail("wd_launch");
`ifdef G729_SEQ_WATCHDOG_EN
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    tests++; if (n !== 66) fail("wd_len");
    tests++; if (error !== 1'b1) fail("wd_error");
    tests++; if (muxSel !== 3'd6) fail("wd_mux");
    tests++; if (busy !== 1'b0) fail("wd_busy");
    tick();
    tests++; if (error !== 1'b1) fail("wd_hold");
    dead  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (error !== 1'b0) fail("wd_clear");
    tests++; if (busy !== 1'b1) fail("wd_rebusy");
`else
    repeat (200) tick();
    tests++; if (error !== 1'b0) fail("nowd_error");
    tests++; if (busy !== 1'b1) fail("nowd_busy");
    tests++; if (muxSel !== 3'd2) fail("nowd_mux");
    tests++; if (done !== 1'b0) fail("nowd_done");
`endif
    reset = 1'b1;
    dead  = '0;
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
